mul_controller: RTL and testbench
=================================

MUL_CONTROLLER -- requirements
Module: mul_controller

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 32, operand width and iteration count.
REQ-002 Ports SHALL be, clock and reset first:
  clk  in  1  rising-edge clock.
  rst  in  1  asynchronous, active-high reset.
  start  in  1  request a multiply.
  data_valid  in  1  operand present on the datapath data_in bus.
  zero_op  in  1  datapath status: at least one loaded operand is zero.
  sign_neg  in  1  datapath status: operand signs differ.
  q_lsb  in  1  current multiplier LSB from datapath.
  ldM  out  1  load multiplicand register.
  ldQ  out  1  load multiplier register.
  clrA  out  1  clear accumulator.
  add_en  out  1  accumulate multiplicand this cycle.
  shift  out  1  shift accumulator/multiplier right one bit.
  comp_en  out  1  two's-complement the product.
  busy  out  1  operation in progress.
  done  out  1  result valid, one-cycle pulse.
  iter_cnt  out  clog2(WIDTH)+1  iterations completed.
REQ-003 Reset SHALL be asynchronous and active-high; it is the only reset, and clk is the only clock.

Function
REQ-004 The block SHALL be an FSM with states IDLE, LOAD_M, LOAD_Q, CHECK, ITER, FIX, DONE.
REQ-005 IDLE: start=1 at an edge -> LOAD_M; otherwise remain.
REQ-006 LOAD_M: ldM = data_valid (combinational); data_valid=1 at an edge -> LOAD_Q; otherwise wait indefinitely.
REQ-007 LOAD_Q: ldQ = data_valid; data_valid=1 at an edge -> CHECK; otherwise wait.
REQ-008 CHECK (one cycle):
  - clrA=1.
  - sign_neg registered into internal sign_q.
  - iter_cnt cleared to 0.
  - zero_op=1 -> DONE (iterations skipped, product stays 0, no FIX); else -> ITER.
REQ-009 ITER:
  - shift=1; add_en=q_lsb.
  - iter_cnt increments each edge.
  - after exactly WIDTH ITER cycles (iter_cnt reaches WIDTH) -> FIX if sign_q=1, else DONE.
REQ-010 FIX: comp_en=1 for exactly one cycle -> DONE.
REQ-011 DONE: done=1 for exactly one cycle -> IDLE; start is ignored in DONE.
REQ-012 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored and not queued.
REQ-013 ldM, ldQ, clrA, add_en, shift and comp_en SHALL be 0 outside the states named above; at most one of ldM/ldQ/clrA/comp_en high per cycle.
REQ-014 Latency with data_valid constantly high, start sampled at edge 0:
  - done high in cycle WIDTH+5 when sign_q=1.
  - done high in cycle WIDTH+4 when sign_q=0.
  - done high in cycle 4 when zero_op=1.
REQ-015 sign_neg and zero_op SHALL be sampled only in CHECK; changes elsewhere have no effect.
REQ-016 iter_cnt SHALL hold its final value through FIX, DONE and IDLE until the next CHECK.

Reset
REQ-017 While rst=1, in any state, including mid-ITER: state=IDLE, iter_cnt=0, sign_q=0, and all outputs 0 immediately, without waiting for clk.
REQ-018 After rst deasserts, the first start SHALL begin a full sequence from LOAD_M; no partial operation resumes.

Verification
REQ-019 WIDTH=32, operands 6 and 7, zero_op=0, sign_neg=0, data_valid held high:
  - ldM in cycle 1, ldQ in cycle 2, clrA in cycle 3.
  - shift high for cycles 4-35, comp_en never asserted.
  - done in cycle 36, iter_cnt=32.
REQ-020 Operands -3 and 5, sign_neg=1 in CHECK: comp_en in cycle 36 only, done in cycle 37.
REQ-021 zero_op=1 in CHECK: shift never asserted, done in cycle 4, iter_cnt=0.
REQ-022 data_valid low for 5 cycles in LOAD_M, then high: ldM asserts only on the first data_valid cycle, and all later events shift by 5 cycles.
REQ-023 rst pulsed during ITER (iter_cnt=10): outputs 0 asynchronously and busy=0; next start gives a full sequence ending with iter_cnt=32.
REQ-024 start held high continuously: exactly one operation per IDLE visit; start in DONE is not accepted; a new LOAD_M follows only after one IDLE cycle.

Source files
------------

// File: rtl/mul_controller.sv
// Control FSM for a sequential shift-add multiplier: sequences operand loads, WIDTH
// shift/add iterations, an optional sign fix-up and a one-cycle done pulse.
module mul_controller #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   data_valid,
  input  logic                   zero_op,
  input  logic                   sign_neg,
  input  logic                   q_lsb,
  output logic                   ldM,
  output logic                   ldQ,
  output logic                   clrA,
  output logic                   add_en,
  output logic                   shift,
  output logic                   comp_en,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(WIDTH):0] iter_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadM,
    StLoadQ,
    StCheck,
    StIter,
    StFix,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sign_q, sign_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoadM;
      StLoadM: if (data_valid) state_d = StLoadQ;
      StLoadQ: if (data_valid) state_d = StCheck;
      StCheck: begin
        // Status flags are only trusted here, once both operands are loaded.
        sign_d  = sign_neg;
        cnt_d   = '0;
        state_d = zero_op ? StDone : StIter;
      end
      StIter: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = sign_q ? StFix : StDone;
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
    end
  end

  // Decoded from the state register so a reset clears every strobe immediately.
  always_comb begin
    ldM     = 1'b0;
    ldQ     = 1'b0;
    clrA    = 1'b0;
    add_en  = 1'b0;
    shift   = 1'b0;
    comp_en = 1'b0;
    done    = 1'b0;
    busy    = (state_q != StIdle);
    unique case (state_q)
      StLoadM: ldM = data_valid;
      StLoadQ: ldQ = data_valid;
      StCheck: clrA = 1'b1;
      StIter: begin
        shift  = 1'b1;
        add_en = q_lsb;
      end
      StFix:   comp_en = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_mul_controller.sv
// Scoreboard bench for mul_controller: each operation pushes its expected event timeline,
// a negedge monitor gathers observed events and compares them when done pulses.
module tb_mul_controller;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, data_valid = 1'b0, zero_op = 1'b0, sign_neg = 1'b0;
  logic          q_lsb = 1'b0;
  logic          ldM, ldQ, clrA, add_en, shift, comp_en, busy, done;
  logic [CW-1:0] iter_cnt;
  logic [7:0]    outs;

  assign outs = {ldM, ldQ, clrA, add_en, shift, comp_en, busy, done};

  mul_controller #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_valid(data_valid),
    .zero_op   (zero_op),
    .sign_neg  (sign_neg),
    .q_lsb     (q_lsb),
    .ldM       (ldM),
    .ldQ       (ldQ),
    .clrA      (clrA),
    .add_en    (add_en),
    .shift     (shift),
    .comp_en   (comp_en),
    .busy      (busy),
    .done      (done),
    .iter_cnt  (iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t0;
    int ldm;
    int ldq;
    int clra;
    int sh_first;
    int sh_n;
    int comp;
    int done;
    int iter;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_iter = 0;
  int   m_ldm, m_ldm_n, m_ldq, m_ldq_n, m_clra, m_clra_n, m_sh_first, m_sh_n;
  int   m_comp, m_comp_n, m_add_err, m_busy_err, m_mux_err;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic void clear_mon();
    m_ldm = 0; m_ldm_n = 0; m_ldq = 0; m_ldq_n = 0; m_clra = 0; m_clra_n = 0;
    m_sh_first = 0; m_sh_n = 0; m_comp = 0; m_comp_n = 0;
    m_add_err = 0; m_busy_err = 0; m_mux_err = 0;
  endfunction

  // Cycle 1 is the cycle right after the edge that samples start.
  function automatic exp_t make_exp(input int t0, input bit zero, input bit sign, input int d);
    exp_t e;
    e.t0       = t0;
    e.ldm      = 1 + d;
    e.ldq      = 2 + d;
    e.clra     = 3 + d;
    e.sh_first = zero ? 0 : 4 + d;
    e.sh_n     = zero ? 0 : W;
    e.comp     = (!zero && sign) ? W + 4 + d : 0;
    e.done     = zero ? 4 + d : (sign ? W + 5 + d : W + 4 + d);
    e.iter     = zero ? 0 : W;
    return e;
  endfunction

  always @(negedge clk) begin
    int   cyc;
    exp_t e;
    bit   in_iter;
    if (!rst) begin
      cyc = (sb.size() == 0) ? 0 : edge_cnt - sb[0].t0 + 1;
      if (cyc <= 0) begin
        check("idle_outs", int'(outs), 0);
        check("idle_iter_hold", int'(iter_cnt), last_iter);
      end else begin
        e = sb[0];
        if (ldM)  begin if (m_ldm == 0)  m_ldm = cyc;  m_ldm_n++;  end
        if (ldQ)  begin if (m_ldq == 0)  m_ldq = cyc;  m_ldq_n++;  end
        if (clrA) begin if (m_clra == 0) m_clra = cyc; m_clra_n++; end
        if (shift) begin if (m_sh_first == 0) m_sh_first = cyc; m_sh_n++; end
        if (comp_en) begin if (m_comp == 0) m_comp = cyc; m_comp_n++; end
        in_iter = (e.sh_n > 0) && (cyc >= e.sh_first) && (cyc < e.sh_first + e.sh_n);
        if (add_en !== (in_iter & q_lsb)) m_add_err++;
        if (busy !== 1'b1) m_busy_err++;
        if (int'(ldM) + int'(ldQ) + int'(clrA) + int'(comp_en) > 1) m_mux_err++;
        if (done) begin
          check("ldm_cycle", m_ldm, e.ldm);
          check("ldm_count", m_ldm_n, 1);
          check("ldq_cycle", m_ldq, e.ldq);
          check("ldq_count", m_ldq_n, 1);
          check("clra_cycle", m_clra, e.clra);
          check("clra_count", m_clra_n, 1);
          check("shift_first", m_sh_first, e.sh_first);
          check("shift_count", m_sh_n, e.sh_n);
          check("comp_cycle", m_comp, e.comp);
          check("comp_count", m_comp_n, (e.comp != 0) ? 1 : 0);
          check("done_cycle", cyc, e.done);
          check("done_iter", int'(iter_cnt), e.iter);
          check("add_en_errs", m_add_err, 0);
          check("busy_errs", m_busy_err, 0);
          check("onehot_errs", m_mux_err, 0);
          last_iter = e.iter;
          void'(sb.pop_front());
          clear_mon();
        end else if (cyc > e.done + 3) begin
          check("done_timeout", 0, 1);
          last_iter = int'(iter_cnt);
          void'(sb.pop_front());
          clear_mon();
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("drain", sb.size(), 0);
      sb.delete();
      clear_mon();
    end
  endtask

  // scr drives the opposite zero/sign values in every cycle except CHECK.
  task automatic run_op(input bit zero, input bit sign, input int d, input bit scr);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e = make_exp(edge_cnt, zero, sign, d);
    sb.push_back(e);
    start = 1'b0;
    for (int k = 1; k <= e.done; k++) begin
      data_valid = (k > d);
      q_lsb      = 1'($urandom_range(0, 1));
      zero_op    = (scr && k != 3 + d) ? ~zero : zero;
      sign_neg   = (scr && k != 3 + d) ? ~sign : sign;
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic run_reset_mid_iter();
    @(negedge clk);
    start = 1'b1; data_valid = 1'b1; zero_op = 1'b0; sign_neg = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back(make_exp(edge_cnt, 1'b0, 1'b0, 0));
    start = 1'b0;
    for (int k = 0; k < 100 && int'(iter_cnt) != 10; k++) begin
      q_lsb = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check("rst_reach_iter10", int'(iter_cnt), 10);
    #2;
    rst = 1'b1;
    sb.delete();
    clear_mon();
    last_iter = 0;
    #1;
    check("rst_async_outs", int'(outs), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_iter", int'(iter_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1'b0, 1'b0, 0, 1'b0);
  endtask

  // start held high: second op must begin only after one IDLE cycle following DONE.
  task automatic run_back_to_back();
    int t0;
    @(negedge clk);
    start = 1'b1; data_valid = 1'b1; zero_op = 1'b0; sign_neg = 1'b0;
    @(posedge clk);
    #1;
    t0 = edge_cnt;
    sb.push_back(make_exp(t0, 1'b0, 1'b0, 0));
    sb.push_back(make_exp(t0 + W + 5, 1'b0, 1'b0, 0));
    for (int k = 1; k <= 2 * W + 9; k++) begin
      start = (k < 2 * W + 9);
      q_lsb = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_mon();
    #1;
    check("reset_outs", int'(outs), 0);
    check("reset_iter", int'(iter_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1'b0, 1'b0, 0, 1'b0);  // 6 x 7
    run_op(1'b0, 1'b1, 0, 1'b0);  // -3 x 5
    run_op(1'b1, 1'b0, 0, 1'b0);  // zero operand
    run_op(1'b0, 1'b0, 5, 1'b0);  // data_valid late in LOAD_M
    run_op(1'b0, 1'b1, 0, 1'b1);
    run_op(1'b0, 1'b0, 2, 1'b1);
    run_op(1'b1, 1'b1, 0, 1'b1);
    run_reset_mid_iter();
    run_back_to_back();
    run_op(1'b0, 1'b1, 3, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
